// File: rtl/bp_be_fdivsqrt_ctl.sv
// bp_be_fdivsqrt_ctl: sequencer for the shared iterative recoded-FP divide/sqrt unit.
//  Accepts one FDIV/FSQRT request, issues it to the unit, waits for the result,
//  tags it and holds it for writeback; handles pipeline poison.
//  Ports: clk_i/reset_n_i (async active-low); v_i/ready_o request handshake with
//  op_i/tag_i/frm_i/rd_addr_i/a_i/b_i/poison_i; unit_* issue/result interface;
//  v_o/yumi_i result handshake with data_o/fflags_o/rd_addr_o; busy_o, lat_cnt_o status.
//  Optional feature macro BP_BE_FDIVSQRT_NAN_BYPASS_EN: NaN operands bypass the unit.
module bp_be_fdivsqrt_ctl #(
  parameter int dpath_width_p    = 66,
  parameter int rec_width_p      = 65,
  parameter int reg_addr_width_p = 5,
  parameter int lat_cnt_width_p  = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic                        op_i,
  input  logic                        tag_i,
  input  logic [2:0]                  frm_i,
  input  logic [reg_addr_width_p-1:0] rd_addr_i,
  input  logic [dpath_width_p-1:0]    a_i,
  input  logic [dpath_width_p-1:0]    b_i,
  input  logic                        poison_i,
  output logic                        unit_v_o,
  input  logic                        unit_ready_i,
  output logic                        unit_op_o,
  output logic [2:0]                  unit_frm_o,
  output logic [rec_width_p-1:0]      unit_a_o,
  output logic [rec_width_p-1:0]      unit_b_o,
  input  logic                        unit_v_i,
  input  logic [rec_width_p-1:0]      unit_rec_i,
  input  logic [4:0]                  unit_fflags_i,
  output logic                        v_o,
  input  logic                        yumi_i,
  output logic [dpath_width_p-1:0]    data_o,
  output logic [4:0]                  fflags_o,
  output logic [reg_addr_width_p-1:0] rd_addr_o,
  output logic                        busy_o,
  output logic [lat_cnt_width_p-1:0]  lat_cnt_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  state_e                      state_q, state_d;
  logic                        poisoned_q, poisoned_d;
  logic [lat_cnt_width_p-1:0]  lat_q, lat_d;
  logic                        op_q, op_d, tag_q, tag_d;
  logic [2:0]                  frm_q, frm_d;
  logic [reg_addr_width_p-1:0] rd_addr_q, rd_addr_d;
  logic [rec_width_p-1:0]      a_q, a_d, b_q, b_d;
  logic [dpath_width_p-1:0]    data_q, data_d;
  logic [4:0]                  fflags_q, fflags_d;
  logic                        accept;
  // The tag bit of the operands travels separately on tag_i.
  logic                        unused_tag_bits;
  assign unused_tag_bits = a_i[dpath_width_p-1] ^ b_i[dpath_width_p-1];
`ifdef BP_BE_FDIVSQRT_NAN_BYPASS_EN
  localparam logic [dpath_width_p-1:0] dp_canonical_reg = 66'h0_e008000000000000;
  localparam logic [dpath_width_p-1:0] sp_canonical_reg = 66'h2_e008000000000000;
  logic a_nan, b_nan, nan_any, snan_any;
  // b is only an operand for divide; recoded NaN has exp[63:61]==3'b111, quiet bit is 51.
  assign a_nan    = a_i[63:61] == 3'b111;
  assign b_nan    = ~op_i & (b_i[63:61] == 3'b111);
  assign nan_any  = a_nan | b_nan;
  assign snan_any = (a_nan & ~a_i[51]) | (b_nan & ~b_i[51]);
`endif
  assign ready_o    = reset_n_i & (state_q == IDLE) & ~poison_i;
  assign accept     = v_i & ready_o;
  assign unit_v_o   = (state_q == ISSUE) & ~poison_i;
  assign v_o        = (state_q == DONE) & ~poison_i;
  assign busy_o     = state_q != IDLE;
  assign unit_op_o  = op_q;
  assign unit_frm_o = frm_q;
  assign unit_a_o   = a_q;
  assign unit_b_o   = b_q;
  assign data_o     = data_q;
  assign fflags_o   = fflags_q;
  assign rd_addr_o  = rd_addr_q;
  assign lat_cnt_o  = lat_q;
  always_comb begin
    state_d    = state_q;
    poisoned_d = poisoned_q;
    lat_d      = lat_q;
    op_d       = op_q;
    tag_d      = tag_q;
    frm_d      = frm_q;
    rd_addr_d  = rd_addr_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    fflags_d   = fflags_q;
    unique case (state_q)
      IDLE: if (accept) begin
        op_d      = op_i;
        tag_d     = tag_i;
        frm_d     = frm_i;
        rd_addr_d = rd_addr_i;
        a_d       = a_i[rec_width_p-1:0];
        b_d       = b_i[rec_width_p-1:0];
        state_d   = ISSUE;
`ifdef BP_BE_FDIVSQRT_NAN_BYPASS_EN
        if (nan_any) begin
          state_d  = DONE;
          data_d   = tag_i ? sp_canonical_reg : dp_canonical_reg;
          fflags_d = {snan_any, 4'b0000};
          lat_d    = '0;
        end
`endif
      end
      ISSUE: begin
        lat_d   = '0;
        state_d = poison_i ? IDLE : unit_ready_i ? WAIT : ISSUE;
      end
      WAIT: begin
        lat_d      = &lat_q ? lat_q : lat_q + 1'b1;
        poisoned_d = poisoned_q | poison_i;
        // The unit cannot be aborted, so a poisoned op still waits for its result and drops it.
        if (unit_v_i) begin
          data_d     = {tag_q, unit_rec_i};
          fflags_d   = unit_fflags_i;
          state_d    = (poisoned_q | poison_i) ? IDLE : DONE;
          poisoned_d = 1'b0;
        end
      end
      DONE: state_d = (yumi_i | poison_i) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      poisoned_q <= 1'b0;
      lat_q      <= '0;
      op_q       <= 1'b0;
      tag_q      <= 1'b0;
      frm_q      <= '0;
      rd_addr_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      data_q     <= '0;
      fflags_q   <= '0;
    end else begin
      state_q    <= state_d;
      poisoned_q <= poisoned_d;
      lat_q      <= lat_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      frm_q      <= frm_d;
      rd_addr_q  <= rd_addr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      data_q     <= data_d;
      fflags_q   <= fflags_d;
    end
  end
  // A result pulse outside WAIT is ignored by the FSM but flagged in simulation.
  unit_v_outside_wait: assert property (@(posedge clk_i) disable iff (!reset_n_i) unit_v_i |-> state_q == WAIT)
    else $warning("unit_v_i outside WAIT ignored");
endmodule
